// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register with RAW forwarding and load-use bubble insertion.
// Optional feature macro: EX_FWD_EN (forwarding muxes); when undefined, RAW hazards stall instead.
`default_nettype none

module ex_operand_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   d_rd1,
    input  logic [WIDTH-1:0]   d_rd2,
    input  logic [REGBITS-1:0] d_rs,
    input  logic [REGBITS-1:0] d_rt,
    input  logic [REGBITS-1:0] d_rd,
    input  logic [WIDTH-1:0]   d_signimm,
    input  logic [2:0]         d_alucontrol,
    input  logic               d_alusrc,
    input  logic               d_regdst,
    input  logic               d_regwrite,
    input  logic               d_memwrite,
    input  logic               d_memtoreg,
    input  logic               hold,
    input  logic               flush,
    input  logic               m_regwrite,
    input  logic [REGBITS-1:0] m_writereg,
    input  logic [WIDTH-1:0]   m_aluout,
    input  logic               w_regwrite,
    input  logic [REGBITS-1:0] w_writereg,
    input  logic [WIDTH-1:0]   w_result,
    output logic [WIDTH-1:0]   srca,
    output logic [WIDTH-1:0]   srcb,
    output logic [2:0]         alucontrol,
    output logic [WIDTH-1:0]   e_writedata,
    output logic [REGBITS-1:0] e_writereg,
    output logic               e_regwrite,
    output logic               e_memwrite,
    output logic               e_memtoreg,
    output logic               stall_d
);

    typedef struct packed {
        logic [WIDTH-1:0]   rd1;
        logic [WIDTH-1:0]   rd2;
        logic [REGBITS-1:0] rs;
        logic [REGBITS-1:0] rt;
        logic [REGBITS-1:0] rd;
        logic [WIDTH-1:0]   signimm;
        logic [2:0]         alucontrol;
        logic               alusrc;
        logic               regdst;
        logic               regwrite;
        logic               memwrite;
        logic               memtoreg;
    } ex_fields_t;

    ex_fields_t fields_q, fields_d, capture;
    logic       load_use;
    logic       raw_stall;
    logic [WIDTH-1:0] opa, opb;

    assign capture = '{
        rd1:        d_rd1,
        rd2:        d_rd2,
        rs:         d_rs,
        rt:         d_rt,
        rd:         d_rd,
        signimm:    d_signimm,
        alucontrol: d_alucontrol,
        alusrc:     d_alusrc,
        regdst:     d_regdst,
        regwrite:   d_regwrite,
        memwrite:   d_memwrite,
        memtoreg:   d_memtoreg
    };

    assign load_use = fields_q.memtoreg && (fields_q.rt != '0) &&
                      ((fields_q.rt == d_rs) || (fields_q.rt == d_rt));

`ifdef EX_FWD_EN
    // Memory stage is the younger producer, so it wins over writeback.
    always_comb begin
        opa = fields_q.rd1;
        if (m_regwrite && (m_writereg == fields_q.rs) && (fields_q.rs != '0)) begin
            opa = m_aluout;
        end else if (w_regwrite && (w_writereg == fields_q.rs) && (fields_q.rs != '0)) begin
            opa = w_result;
        end
    end

    always_comb begin
        opb = fields_q.rd2;
        if (m_regwrite && (m_writereg == fields_q.rt) && (fields_q.rt != '0)) begin
            opb = m_aluout;
        end else if (w_regwrite && (w_writereg == fields_q.rt) && (fields_q.rt != '0)) begin
            opb = w_result;
        end
    end

    assign raw_stall = 1'b0;
`else
    logic e_hit, m_hit;
    logic unused_fwd;

    assign opa = fields_q.rd1;
    assign opb = fields_q.rd2;

    assign e_hit = e_regwrite && (e_writereg != '0) &&
                   ((e_writereg == d_rs) || (e_writereg == d_rt));
    assign m_hit = m_regwrite && (m_writereg != '0) &&
                   ((m_writereg == d_rs) || (m_writereg == d_rt));
    assign raw_stall = e_hit || m_hit;

    // Writeback conflicts are resolved by the write-first register file.
    assign unused_fwd = ^{m_aluout, w_regwrite, w_writereg, w_result};
`endif

    assign stall_d = load_use || raw_stall;

    always_comb begin
        fields_d = capture;
        if (flush) begin
            fields_d = '0;
        end else if (hold) begin
            fields_d = fields_q;
        end else if (stall_d) begin
            fields_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fields_q <= '0;
        end else begin
            fields_q <= fields_d;
        end
    end

    assign srca        = opa;
    assign e_writedata = opb;
    assign srcb        = fields_q.alusrc ? fields_q.signimm : opb;
    assign alucontrol  = fields_q.alucontrol;
    assign e_writereg  = fields_q.regdst ? fields_q.rd : fields_q.rt;
    assign e_regwrite  = fields_q.regwrite;
    assign e_memwrite  = fields_q.memwrite;
    assign e_memtoreg  = fields_q.memtoreg;

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage; covers both EX_FWD_EN builds.
`timescale 1ns/1ps

module tb_ex_operand_stage;

    typedef logic [107:0] obs_t;

    logic        clk;
    logic        reset;
    logic [31:0] d_rd1, d_rd2, d_signimm;
    logic [4:0]  d_rs, d_rt, d_rd;
    logic [2:0]  d_alucontrol;
    logic        d_alusrc, d_regdst, d_regwrite, d_memwrite, d_memtoreg;
    logic        hold, flush;
    logic        m_regwrite, w_regwrite;
    logic [4:0]  m_writereg, w_writereg;
    logic [31:0] m_aluout, w_result;
    logic [31:0] srca, srcb, e_writedata;
    logic [2:0]  alucontrol;
    logic [4:0]  e_writereg;
    logic        e_regwrite, e_memwrite, e_memtoreg, stall_d;

    obs_t obs, e;
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_operand_stage #(.WIDTH(32), .REGBITS(5)) dut (
        .clk(clk), .reset(reset),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
        .d_signimm(d_signimm), .d_alucontrol(d_alucontrol), .d_alusrc(d_alusrc),
        .d_regdst(d_regdst), .d_regwrite(d_regwrite), .d_memwrite(d_memwrite),
        .d_memtoreg(d_memtoreg), .hold(hold), .flush(flush),
        .m_regwrite(m_regwrite), .m_writereg(m_writereg), .m_aluout(m_aluout),
        .w_regwrite(w_regwrite), .w_writereg(w_writereg), .w_result(w_result),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .e_writedata(e_writedata),
        .e_writereg(e_writereg), .e_regwrite(e_regwrite), .e_memwrite(e_memwrite),
        .e_memtoreg(e_memtoreg), .stall_d(stall_d)
    );

    assign obs = {srca, srcb, alucontrol, e_writedata, e_writereg,
                  e_regwrite, e_memwrite, e_memtoreg, stall_d};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t ex(input logic [31:0] sa, input logic [31:0] sb,
                                input logic [2:0] ac, input logic [31:0] wd,
                                input logic [4:0] wr, input logic rw, input logic mw,
                                input logic mtr, input logic st);
        return {sa, sb, ac, wd, wr, rw, mw, mtr, st};
    endfunction

    task automatic set_instr(input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] imm, input logic [2:0] ac, input logic asrc,
                             input logic rdst, input logic rw, input logic mw, input logic mtr);
        d_rd1 = rd1; d_rd2 = rd2; d_rs = rs; d_rt = rt; d_rd = rd; d_signimm = imm;
        d_alucontrol = ac; d_alusrc = asrc; d_regdst = rdst;
        d_regwrite = rw; d_memwrite = mw; d_memtoreg = mtr;
    endtask

    task automatic set_nop();
        set_instr(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_instr($urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
                      3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom));
            exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, e);
            end
        end
        reset = 1'b0;
        set_nop();
    endtask

    task automatic test_capture();
        // add $3 = $1 + $2
        set_instr(32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'h100, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(ex(32'd5, 32'd7, 3'b010, 32'd7, 5'd3, 1, 0, 0, 0));
        // addi $5 = $1 + 0x100
        set_instr(32'h20, 32'h30, 5'd1, 5'd5, 5'd0, 32'h100, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(ex(32'h20, 32'h100, 3'b010, 32'h30, 5'd5, 1, 0, 0, 0));
        // sw $2, 4($1)
        set_instr(32'h100, 32'hdead, 5'd1, 5'd2, 5'd0, 32'h4, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(ex(32'h100, 32'h4, 3'b010, 32'hdead, 5'd2, 0, 1, 0, 0));
        // sub $9 = $7 - $8
        set_instr(32'd9, 32'd4, 5'd7, 5'd8, 5'd9, 32'h0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(ex(32'd9, 32'd4, 3'b110, 32'd4, 5'd9, 1, 0, 0, 0));
        // Replay the four instructions in the same order they were queued.
        set_instr(32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'h100, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); set_nop(); #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL capture_add: got %h expected %h", obs, e); end
        set_instr(32'h20, 32'h30, 5'd1, 5'd5, 5'd0, 32'h100, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); set_nop(); #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL capture_addi: got %h expected %h", obs, e); end
        set_instr(32'h100, 32'hdead, 5'd1, 5'd2, 5'd0, 32'h4, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); set_nop(); #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL capture_sw: got %h expected %h", obs, e); end
        set_instr(32'd9, 32'd4, 5'd7, 5'd8, 5'd9, 32'h0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); set_nop(); #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL capture_sub: got %h expected %h", obs, e); end
    endtask

    // Expects the sub from test_capture to be sitting in E.
    task automatic test_hold_flush();
        hold = 1'b1;
        set_instr(32'h77, 32'h88, 5'd10, 5'd11, 5'd12, 32'h5, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex(32'd9, 32'd4, 3'b110, 32'd4, 5'd9, 1, 0, 0, 0));
            tick();
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h expected %h", i, obs, e);
            end
        end
        flush = 1'b1;
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL flush_and_hold: got %h expected %h", obs, e); end
        flush = 1'b0;
        hold = 1'b0;
        set_nop();
    endtask

    task automatic test_load_use();
        // lw $4, 8($1) then add $5 = $4 + $2 in decode
        set_instr(32'h40, 32'h99, 5'd1, 5'd4, 5'd0, 32'h8, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(ex(32'h40, 32'h8, 3'b010, 32'h99, 5'd4, 1, 0, 1, 1));
        exp_q.push_back(ex(32'h40, 32'h8, 3'b010, 32'h99, 5'd4, 1, 0, 1, 1));
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ex(32'h50, 32'h60, 3'b010, 32'h60, 5'd5, 1, 0, 0, 0));
        tick();
        set_instr(32'h50, 32'h60, 5'd4, 5'd2, 5'd5, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL load_use_stall: got %h expected %h", obs, e); end
        hold = 1'b1;
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL hold_over_stall: got %h expected %h", obs, e); end
        hold = 1'b0;
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL load_use_bubble: got %h expected %h", obs, e); end
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL after_bubble: got %h expected %h", obs, e); end
        // Reset arriving while the stall is pending.
        set_instr(32'h40, 32'h99, 5'd1, 5'd4, 5'd0, 32'h8, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        set_instr(32'h50, 32'h60, 5'd4, 5'd2, 5'd5, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_mid_stall: got %h expected %h", obs, e); end
        reset = 1'b0;
        set_nop();
    endtask

`ifdef EX_FWD_EN
    task automatic test_forwarding();
        set_instr(32'hAA, 32'hBB, 5'd3, 5'd3, 5'd9, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_nop();
        m_regwrite = 1'b1; m_writereg = 5'd3; m_aluout = 32'h11;
        w_regwrite = 1'b1; w_writereg = 5'd3; w_result = 32'h22;
        exp_q.push_back(ex(32'h11, 32'h11, 3'b010, 32'h11, 5'd9, 1, 0, 0, 0));
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL fwd_mem_wins: got %h expected %h", obs, e); end
        m_regwrite = 1'b0;
        exp_q.push_back(ex(32'h22, 32'h22, 3'b010, 32'h22, 5'd9, 1, 0, 0, 0));
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL fwd_wb: got %h expected %h", obs, e); end
        m_regwrite = 1'b1; m_writereg = 5'd0; w_writereg = 5'd0;
        set_instr(32'h33, 32'h44, 5'd0, 5'd0, 5'd7, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(ex(32'h33, 32'h44, 3'b010, 32'h44, 5'd7, 1, 0, 0, 0));
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL fwd_reg0: got %h expected %h", obs, e); end
        m_regwrite = 1'b0; w_regwrite = 1'b0;
        set_nop();
        tick();
    endtask
`else
    task automatic test_raw_stall();
        // Producer writes $6; consumer reads $6 while the producer walks E -> M -> W.
        set_instr(32'd1, 32'd2, 5'd1, 5'd2, 5'd6, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(ex(32'd1, 32'd2, 3'b010, 32'd2, 5'd6, 1, 0, 0, 1));
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ex(32'h70, 32'h80, 3'b010, 32'h80, 5'd7, 1, 0, 0, 0));
        tick();
        set_instr(32'h70, 32'h80, 5'd6, 5'd0, 5'd7, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL raw_e_stall: got %h expected %h", obs, e); end
        m_regwrite = 1'b1; m_writereg = 5'd6; m_aluout = 32'h1234;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL raw_m_bubble[%0d]: got %h expected %h", i, obs, e);
            end
        end
        m_regwrite = 1'b0;
        w_regwrite = 1'b1; w_writereg = 5'd6; w_result = 32'hFF;
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL raw_clear: got %h expected %h", obs, e); end
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL raw_no_wb_fwd: got %h expected %h", obs, e); end
        w_regwrite = 1'b0;
        set_nop();
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        m_regwrite = 1'b0; m_writereg = '0; m_aluout = '0;
        w_regwrite = 1'b0; w_writereg = '0; w_result = '0;
        set_nop();
        #1;
        test_reset();
        test_capture();
        test_hold_flush();
        test_load_use();
`ifdef EX_FWD_EN
        test_forwarding();
`else
        test_raw_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
